// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and SELECT encodings, used by the decoder and the
// RV32IM execute-stage ALU.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OpAdd    = 5'b00000;
  localparam logic [4:0] OpSll    = 5'b00001;
  localparam logic [4:0] OpSlt    = 5'b00010;
  localparam logic [4:0] OpSltu   = 5'b00011;
  localparam logic [4:0] OpXor    = 5'b00100;
  localparam logic [4:0] OpSrl    = 5'b00101;
  localparam logic [4:0] OpOr     = 5'b00110;
  localparam logic [4:0] OpAnd    = 5'b00111;
  localparam logic [4:0] OpMul    = 5'b01000;
  localparam logic [4:0] OpMulh   = 5'b01001;
  localparam logic [4:0] OpMulhsu = 5'b01010;
  localparam logic [4:0] OpMulhu  = 5'b01011;
  localparam logic [4:0] OpDiv    = 5'b01100;
  localparam logic [4:0] OpDivu   = 5'b01101;
  localparam logic [4:0] OpRem    = 5'b01110;
  localparam logic [4:0] OpRemu   = 5'b01111;
  localparam logic [4:0] OpSub    = 5'b10000;
  localparam logic [4:0] OpSra    = 5'b10101;
  localparam logic [4:0] OpFwd    = 5'b11111;

endpackage

// File: rtl/alu_muldiv.sv
// Combinational M-extension unit: one shared 64-bit multiplier and one magnitude divider,
// with sign fix-up and the divide-by-zero results.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic            a_sext, b_sext;
  logic [63:0]     prod;
  logic            div_signed, a_neg, b_neg, div_zero;
  logic [XLEN-1:0] dividend, divisor, quot_mag, rem_mag, quot, rem;

  // The low product half does not depend on operand extension, so MUL shares this multiplier.
  assign a_sext = ((op_i == OpMulh) || (op_i == OpMulhsu)) && a_i[XLEN-1];
  assign b_sext = (op_i == OpMulh) && b_i[XLEN-1];
  assign prod   = {{XLEN{a_sext}}, a_i} * {{XLEN{b_sext}}, b_i};

  assign div_signed = (op_i == OpDiv) || (op_i == OpRem);
  assign a_neg      = div_signed && a_i[XLEN-1];
  assign b_neg      = div_signed && b_i[XLEN-1];
  assign dividend   = a_neg ? -a_i : a_i;
  assign divisor    = b_neg ? -b_i : b_i;
  assign div_zero   = (b_i == '0);

  assign quot_mag = dividend / divisor;
  assign rem_mag  = dividend % divisor;
  // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0 without a special case.
  assign quot     = (a_neg ^ b_neg) ? -quot_mag : quot_mag;
  assign rem      = a_neg ? -rem_mag : rem_mag;

  always_comb begin
    result_o = '0;
    case (op_i)
      OpMul:                       result_o = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:   result_o = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:               result_o = div_zero ? '1 : quot;
      OpRem, OpRemu:               result_o = div_zero ? a_i : rem;
      default:                     result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32im_alu.sv
// RV32IM execute-stage ALU: RV32I ops and output mux here, M ops in alu_muldiv.
// RESULT and ZERO are registered one cycle after the operands.
module rv32im_alu
  import alu_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [4:0]      SELECT,
  output logic [XLEN-1:0] RESULT,
  output logic            ZERO
);

  logic [XLEN-1:0] muldiv_result;
  logic [XLEN-1:0] result_d, result_q;
  logic            zero_d, zero_q;
  logic [4:0]      shamt;

  assign shamt = DATA2[4:0];

  alu_muldiv u_muldiv (
    .op_i     (SELECT),
    .a_i      (DATA1),
    .b_i      (DATA2),
    .result_o (muldiv_result)
  );

  always_comb begin
    result_d = '0;
    case (SELECT)
      OpAdd:  result_d = DATA1 + DATA2;
      OpSub:  result_d = DATA1 - DATA2;
      OpSll:  result_d = DATA1 << shamt;
      OpSlt:  result_d = {{(XLEN-1){1'b0}}, $signed(DATA1) < $signed(DATA2)};
      OpSltu: result_d = {{(XLEN-1){1'b0}}, DATA1 < DATA2};
      OpXor:  result_d = DATA1 ^ DATA2;
      OpSrl:  result_d = DATA1 >> shamt;
      OpSra:  result_d = $unsigned($signed(DATA1) >>> shamt);
      OpOr:   result_d = DATA1 | DATA2;
      OpAnd:  result_d = DATA1 & DATA2;
      OpMul, OpMulh, OpMulhsu, OpMulhu,
      OpDiv, OpDivu, OpRem, OpRemu:
              result_d = muldiv_result;
      OpFwd:  result_d = DATA2;
      default: result_d = '0;
    endcase
  end

  assign zero_d = (result_d == '0);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign RESULT = result_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_rv32im_alu.sv
// Bench for rv32im_alu: directed literal vectors plus a randomized stream, all checked every
// cycle against an arithmetic reference model.
module tb_rv32im_alu;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] DATA1, DATA2;
  logic [4:0]  SELECT;
  logic [31:0] RESULT;
  logic        ZERO;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] exp_res = '0;
  bit          exp_valid = 1'b0;

  rv32im_alu dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .SELECT  (SELECT),
    .RESULT  (RESULT),
    .ZERO    (ZERO)
  );

  always #5 CLK = ~CLK;

  // Reference model straight from the RV32IM definitions, using 64-bit arithmetic.
  function automatic logic [31:0] model(logic [4:0] s, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sh = b[4:0];
    case (s)
      5'd0:  return a + b;
      5'd1:  return a << sh;
      5'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd3:  return (ua < ub) ? 32'd1 : 32'd0;
      5'd4:  return a ^ b;
      5'd5:  return a >> sh;
      5'd6:  return a | b;
      5'd7:  return a & b;
      5'd8:  begin p = sa * sb; return p[31:0];  end
      5'd9:  begin p = sa * sb; return p[63:32]; end
      5'd10: begin p = sa * ub; return p[63:32]; end
      5'd11: begin p = ua * ub; return p[63:32]; end
      5'd12: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      5'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd14: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      5'd15: return (b == 0) ? a : a % b;
      5'd16: return a - b;
      5'd21: return $signed(a) >>> sh;
      5'd31: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected output register, fed from the model at each edge.
  always @(posedge CLK) begin
    exp_res   <= RESET_N ? model(SELECT, DATA1, DATA2) : 32'd0;
    exp_valid <= 1'b1;
  end

  always @(negedge CLK) begin
    if (exp_valid) begin
      check("stream_result", RESULT, exp_res);
      check("stream_zero", {31'b0, ZERO}, {31'b0, exp_res == 32'd0});
    end
  end

  task automatic drive(logic rst_n, logic [4:0] s, logic [31:0] a, logic [31:0] b);
    @(posedge CLK);
    #2;
    RESET_N = rst_n;
    SELECT  = s;
    DATA1   = a;
    DATA2   = b;
  endtask

  // Apply one vector, then check the registered result against a hand-computed literal.
  task automatic directed(string name, logic [4:0] s, logic [31:0] a, logic [31:0] b,
                          logic [31:0] lit);
    drive(1'b1, s, a, b);
    @(posedge CLK);
    #1;
    check(name, RESULT, lit);
    check({name, "_zero"}, {31'b0, ZERO}, {31'b0, lit == 32'd0});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RESET_N = 1'b0;
    SELECT  = 5'd0;
    DATA1   = 32'd10;
    DATA2   = 32'd20;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_result", RESULT, 32'd0);
    check("reset_zero", {31'b0, ZERO}, 32'd1);
    #1;
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check("post_reset_add", RESULT, 32'd30);
    check("post_reset_zero", {31'b0, ZERO}, 32'd0);

    directed("add",        5'b00000, 32'd10,          32'd20,          32'd30);
    directed("sub",        5'b10000, 32'd30,          32'd30,          32'd0);
    directed("sll",        5'b00001, 32'd5,           32'd2,           32'd20);
    directed("slt",        5'b00010, 32'd5,           32'd10,          32'd1);
    directed("slt_neg",    5'b00010, 32'hFFFF_FFFF,   32'd1,           32'd1);
    directed("sltu",       5'b00011, 32'hFFFF_FFFF,   32'd1,           32'd0);
    directed("sra",        5'b10101, 32'h8000_0000,   32'd4,           32'hF800_0000);
    directed("srl",        5'b00101, 32'h8000_0000,   32'd4,           32'h0800_0000);
    directed("sll_33",     5'b00001, 32'd5,           32'd33,          32'd10);
    directed("mul",        5'b01000, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'd1);
    directed("mulh",       5'b01001, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'd0);
    directed("mulhu",      5'b01011, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFE);
    directed("mulhsu",     5'b01010, 32'hFFFF_FFFF,   32'd2,           32'hFFFF_FFFF);
    directed("div_zero",   5'b01100, 32'd7,           32'd0,           32'hFFFF_FFFF);
    directed("remu_zero",  5'b01111, 32'd7,           32'd0,           32'd7);
    directed("div_ovf",    5'b01100, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000);
    directed("rem_ovf",    5'b01110, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0);
    directed("div_neg",    5'b01100, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD);
    directed("rem_neg",    5'b01110, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF);
    directed("fwd",        5'b11111, 32'hDEAD_BEEF,   32'h1234_5000,   32'h1234_5000);
    directed("unused",     5'b11000, 32'd55,          32'd66,          32'd0);

    // Back-to-back random stream with occasional mid-stream resets.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 31) != 0), 5'($urandom), pick(), pick());
    end
    drive(1'b1, 5'b00000, 32'd1, 32'd1);
    repeat (2) @(posedge CLK);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
